rgb2ycc_stream_ctrl: RTL and testbench



---
 rtl/rgb2ycc_stream_ctrl.sv | 153 +++++++++++++++
 tb/tb_rgb2ycc_stream_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycc_stream_ctrl.sv
// Ready/valid sequencer around a fixed-latency RGB->YCbCr converter with a credit-guarded output FIFO.
// Optional performance counters (stall_cnt, blk_cnt) are enabled by defining RGB2YCC_PERF_EN.
module rgb2ycc_stream_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int CVT_LATENCY = 2,
    parameter int BLK_PIXELS  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  cvt_r,
    output logic [7:0]  cvt_g,
    output logic [7:0]  cvt_b,
    input  logic [29:0] cvt_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_y,
    output logic [9:0]  out_cb,
    output logic [9:0]  out_cr,
    output logic        out_last,
    output logic        busy
`ifdef RGB2YCC_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] blk_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + CVT_LATENCY + 1) + 1;
    localparam int BW = (BLK_PIXELS > 1) ? $clog2(BLK_PIXELS) : 1;
    localparam int EW = 31;

    logic [CVT_LATENCY-1:0] vld_pipe;
    logic [CVT_LATENCY-1:0] last_pipe;
    logic [BW-1:0]          pix_cnt;
    logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          inflight;
    logic [EW-1:0]          hold_q;
    logic [EW-1:0]          head;
    logic [EW-1:0]          out_word;
    logic                   fire;
    logic                   pix_last;
    logic                   push;
    logic                   pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cvt_r = in_r;
    assign cvt_g = in_g;
    assign cvt_b = in_b;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < CVT_LATENCY; k++) begin
            inflight = inflight + CW'(vld_pipe[k]);
        end
    end

    // Credits come only from registered state, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign fire      = in_valid & in_ready;
    assign pix_last  = (pix_cnt == BW'(BLK_PIXELS - 1));
    assign push      = vld_pipe[CVT_LATENCY-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign busy      = (inflight != '0) | out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= fire;
            last_pipe[0] <= fire & pix_last;
            for (int k = 1; k < CVT_LATENCY; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (fire) begin
            pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            hold_q     <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_mem[k] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {last_pipe[CVT_LATENCY-1], cvt_out};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                hold_q <= head;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Once drained, outputs keep showing the most recently popped entry rather than a stale slot.
    assign head     = fifo_mem[rd_ptr];
    assign out_word = out_valid ? head : hold_q;
    assign out_last = out_word[30];
    assign out_y    = out_word[29:20];
    assign out_cb   = out_word[19:10];
    assign out_cr   = out_word[9:0];

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fifo_count == CW'(FIFO_DEPTH))));

`ifdef RGB2YCC_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            blk_cnt   <= '0;
        end else begin
            if (in_valid && !in_ready && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (pop && head[30] && !(&blk_cnt)) begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rgb2ycc_stream_ctrl.sv
// Randomised self-checking bench for rgb2ycc_stream_ctrl with a converter model and an ordered scoreboard.
module tb_rgb2ycc_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0]  in_r, in_g, in_b, cvt_r, cvt_g, cvt_b;
    logic [29:0] cvt_out, cvt_stage;
    logic [9:0]  out_y, out_cb, out_cr;
`ifdef RGB2YCC_PERF_EN
    logic [31:0] stall_cnt, blk_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    logic [30:0] exp_q[$];
    logic [30:0] exp_word;
    int          pix_idx = 0;
    int          pop_count = 0;
    int          last_pops = 0;
    int          stall_cycles = 0;

    always #5 clk = ~clk;

    rgb2ycc_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .cvt_r(cvt_r), .cvt_g(cvt_g), .cvt_b(cvt_b),
        .cvt_out(cvt_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
        .out_last(out_last), .busy(busy)
`ifdef RGB2YCC_PERF_EN
        , .stall_cnt(stall_cnt), .blk_cnt(blk_cnt)
`endif
    );

    // Integer BT.601-style conversion, level-shifted Y, packed as the converter presents it.
    function automatic logic [29:0] ycc(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int ri, gi, bi, y, cb, cr;
        ri = int'(r);
        gi = int'(g);
        bi = int'(b);
        y  = ((77 * ri + 150 * gi + 29 * bi) >>> 8) - 128;
        cb = (-43 * ri - 85 * gi + 128 * bi) >>> 8;
        cr = (128 * ri - 107 * gi - 21 * bi) >>> 8;
        return {y[9:0], cb[9:0], cr[9:0]};
    endfunction

    // External converter: free-running, two-clock latency, never stalls.
    always @(posedge clk) begin
        cvt_stage <= ycc(cvt_r, cvt_g, cvt_b);
        cvt_out   <= cvt_stage;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_r      = r;
        in_g      = g;
        in_b      = b;
        out_ready = ordy;
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        exp_q.delete();
        pix_idx      = 0;
        pop_count    = 0;
        last_pops    = 0;
        stall_cycles = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard: every accepted pixel must emerge once, in order, with last on each 64th pixel.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({(pix_idx % 64) == 63, ycc(in_r, in_g, in_b)});
                pix_idx++;
            end
            if (in_valid && !in_ready) stall_cycles++;
            if (out_valid && out_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", {out_last, out_y, out_cb, out_cr}, 64'h0);
                end else begin
                    exp_word = exp_q.pop_front();
                    checkOutput("out_data", {out_last, out_y, out_cb, out_cr}, exp_word);
                    if (out_last) last_pops++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, busy_after, first, last, n, accepted, sent, cyc;
        logic [9:0] y_seen;
        logic [7:0] pr;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        #12;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_y", out_y, 0);
        checkOutput("rst_out_last", out_last, 0);
        doReset();

        // Single black pixel: latency, level-shifted Y and busy fall-off.
        applyStimulus(1, 8'd0, 8'd0, 8'd0, 1);
        @(negedge clk);
        checkOutput("single_accept", in_ready, 1);
        lat = 0; busy_after = -1; y_seen = '0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 8'd0, 8'd0, 8'd0, 1);
            @(negedge clk);
            if (out_valid && lat == 0) begin
                lat = k;
                y_seen = out_y;
            end
            if (lat != 0 && k == lat + 1) busy_after = int'(busy);
        end
        checkOutput("single_latency", lat, 3);
        checkOutput("single_y", y_seen, 10'h380);
        checkOutput("single_busy_after", busy_after, 0);

        // Full block of white pixels back to back.
        doReset();
        first = -1; last = -1; n = 0;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(i < 64, 8'd255, 8'd255, 8'd255, 1);
            @(negedge clk);
            if (i < 64) checkOutput("stream_in_ready", in_ready, 1);
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
        end
        checkOutput("stream_count", n, 64);
        checkOutput("stream_first", first, 3);
        checkOutput("stream_span", last - first, 63);
        checkOutput("stream_lasts", last_pops, 1);

        // Back-pressure: four credits, then stall until drained.
        doReset();
        accepted = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 8'(accepted * 10 + 5), 8'(accepted * 3), 8'd100, 0);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
        end
        checkOutput("bp_accepted", accepted, 4);
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_full_valid", out_valid, 1);
        applyStimulus(0, 8'd0, 8'd0, 8'd0, 1);
        @(negedge clk);
        checkOutput("bp_ready_at_first_pop", in_ready, 0);
`ifdef RGB2YCC_PERF_EN
        checkOutput("perf_stall_model", stall_cnt, stall_cycles);
        checkOutput("perf_stall_10", stall_cnt, 10);
`endif
        applyStimulus(0, 8'd0, 8'd0, 8'd0, 1);
        @(negedge clk);
        checkOutput("bp_ready_after_pop", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 8'd0, 8'd0, 8'd0, 1);
            @(negedge clk);
        end
        checkOutput("bp_pops", pop_count, 4);
        checkOutput("bp_queue_empty", exp_q.size(), 0);

        // Random handshakes on both sides over 200 incrementing pixels.
        doReset();
        pr = 8'd0; sent = 0; cyc = 0;
        while (sent < 200 && cyc < 5000) begin
            applyStimulus(1'($urandom % 2), pr, pr + 8'd1, pr + 8'd2, 1'($urandom % 2));
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                pr = pr + 8'd1;
            end
            cyc++;
        end
        checkOutput("rand_sent", sent, 200);
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 200) begin
            applyStimulus(0, 8'd0, 8'd0, 8'd0, 1);
            @(negedge clk);
            cyc++;
        end
        checkOutput("rand_pops", pop_count, 200);
        checkOutput("rand_queue_empty", exp_q.size(), 0);
        checkOutput("rand_idle", busy, 0);
        checkOutput("rand_lasts", last_pops, 3);
`ifdef RGB2YCC_PERF_EN
        checkOutput("perf_blk_cnt", blk_cnt, last_pops);
`endif

        // Reset with pixels both in flight and buffered.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'(i * 3), 8'd7, 8'd9, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_y", out_y, 0);
        checkOutput("midrst_out_last", out_last, 0);
        doReset();
        for (int i = 0; i < 72; i++) begin
            applyStimulus(i < 64, 8'($urandom), 8'($urandom), 8'($urandom), 1);
            @(negedge clk);
        end
        checkOutput("midrst_pops", pop_count, 64);
        checkOutput("midrst_lasts", last_pops, 1);
        checkOutput("midrst_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
